// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the RISC-V core front end.
//   XLEN             : datapath width
//   NOP_INST         : bubble instruction (addi x0,x0,0)
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_state_e    : instruction-fetch sequencer states
//   align_pc()       : clear the low two bits of a fetch target
package riscv_pipe_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

    // REQ: request outstanding-free, WAIT: awaiting response, KILL: awaiting a squashed response
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_e;

    // Fetch targets are word aligned; the low bits of a redirect are ignored.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry pc+instruction holding register used when the IF output slot is
// stalled while a fetch response arrives.
//   clk, nrst        : clock, synchronous active-low reset
//   flush_i          : discard the held entry (highest priority)
//   load_i           : capture pc_i/inst_i
//   drain_i          : entry moved downstream, mark empty
//   pc_i, inst_i     : entry to capture
//   valid_o, pc_o, inst_o : held entry
module if_skid_buffer
    import riscv_pipe_pkg::*;
(
    input  logic            clk,
    input  logic            nrst,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic            drain_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;

    // Entry register: flush beats load beats drain
    always_ff @(posedge clk) begin
        if (!nrst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= NOP_INST;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            inst_q  <= inst_i;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/stage_if_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to
// instruction memory and drives the pc/instruction pair captured by IF/ID.
// Stall back-pressure is absorbed by a one-entry skid buffer; redirects squash
// in-flight and buffered fetches and present a NOP bubble.
//   clk, nrst              : clock, synchronous active-low reset
//   imem_req/imem_addr     : fetch request and address (addr = pc register)
//   imem_gnt               : request accepted
//   imem_rvalid/imem_rdata : fetch response
//   stall_i                : ID cannot accept, hold the output slot
//   redirect_i/redirect_pc_i : taken branch/jump target from EX
//   if_valid_o/if_pc_o/if_inst_o : output slot towards IF/ID
module stage_if_fetch
    import riscv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            nrst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_inst_o
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic            slot_valid_q;
    logic [XLEN-1:0] slot_pc_q;
    logic [XLEN-1:0] slot_inst_q;

    logic            sk_valid;
    logic [XLEN-1:0] sk_pc;
    logic [XLEN-1:0] sk_inst;

    logic            gnt_fire;
    logic            deliver;
    logic            slot_open;
    logic            slot_held;
    logic [XLEN-1:0] pc_inc_d;

    // No new request while the skid is occupied, so a response never lands on a full skid
    assign imem_req  = nrst && (state_q == REQ) && !sk_valid;
    assign imem_addr = pc_q;

    assign gnt_fire  = imem_req && imem_gnt;
    assign deliver   = (state_q == WAIT) && imem_rvalid && !redirect_i;
    assign slot_open = !slot_valid_q || !stall_i;
    assign slot_held = slot_valid_q && stall_i;
    assign pc_inc_d  = pc_q + PC_STEP;

    if_skid_buffer u_skid (
        .clk     (clk),
        .nrst    (nrst),
        .flush_i (redirect_i),
        .load_i  (deliver && slot_held),
        .drain_i (slot_open && sk_valid),
        .pc_i    (req_pc_q),
        .inst_i  (imem_rdata),
        .valid_o (sk_valid),
        .pc_o    (sk_pc),
        .inst_o  (sk_inst)
    );

    // Fetch sequencer, PC and output slot
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            slot_valid_q <= 1'b0;
            slot_pc_q    <= '0;
            slot_inst_q  <= NOP_INST;
        end else if (redirect_i) begin
            // Squash: bubble the slot and retarget; an accepted or pending
            // response still has to be absorbed in KILL before refetching.
            pc_q         <= align_pc(redirect_pc_i);
            slot_valid_q <= 1'b0;
            slot_inst_q  <= NOP_INST;
            unique case (state_q)
                REQ:     state_q <= gnt_fire    ? KILL : REQ;
                WAIT:    state_q <= imem_rvalid ? REQ  : KILL;
                KILL:    state_q <= imem_rvalid ? REQ  : KILL;
                default: state_q <= REQ;
            endcase
        end else begin
            unique case (state_q)
                REQ: begin
                    if (gnt_fire) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_inc_d;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_q <= REQ;
                    end
                end
                KILL: begin
                    if (imem_rvalid) begin
                        state_q <= REQ;
                    end
                end
                default: state_q <= REQ;
            endcase

            // Skid content is older than any new response, so it refills the slot first
            if (slot_open) begin
                if (sk_valid) begin
                    slot_valid_q <= 1'b1;
                    slot_pc_q    <= sk_pc;
                    slot_inst_q  <= sk_inst;
                end else if (deliver) begin
                    slot_valid_q <= 1'b1;
                    slot_pc_q    <= req_pc_q;
                    slot_inst_q  <= imem_rdata;
                end else begin
                    slot_valid_q <= 1'b0;
                    slot_inst_q  <= NOP_INST;
                end
            end
        end
    end

    assign if_valid_o = slot_valid_q;
    assign if_pc_o    = slot_pc_q;
    assign if_inst_o  = slot_inst_q;

endmodule

// File: tb/tb_stage_if_fetch.sv
// Self-checking bench for stage_if_fetch: a cycle-exact directed vector table
// with a zero/fixed-latency memory, then randomized stall/redirect/memory
// timing checked against an in-order instruction-stream scoreboard.
module tb_stage_if_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_inst;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stage_if_fetch u_dut (
        .clk           (clk),
        .nrst          (nrst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o)
    );

    // Second instance only to observe PC wrap from the top of the address space
    stage_if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk           (clk),
        .nrst          (nrst),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_gnt      (w_gnt),
        .imem_rvalid   (w_rvalid),
        .imem_rdata    (w_rdata),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .if_valid_o    (w_valid),
        .if_pc_o       (w_pc),
        .if_inst_o     (w_inst)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ SALT;
    endfunction

    // Zero-wait memory for the wrap instance
    assign w_gnt = w_req;
    always @(posedge clk) begin
        w_rvalid <= w_gnt && nrst;
        w_rdata  <= word_at(w_addr);
    end

    // Main memory: one outstanding access, latency fixed (mem_lat) or random
    bit          mem_rand = 1'b0;
    int          mem_lat  = 0;
    bit          mem_busy = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = '0;

    always @(negedge clk) begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        if (!nrst) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            if (mem_wait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_at(mem_addr);
                mem_busy    = 1'b0;
            end else begin
                mem_wait = mem_wait - 1;
            end
        end else if (imem_req && (!mem_rand || $urandom_range(0, 2) != 0)) begin
            imem_gnt = 1'b1;
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_wait = mem_rand ? int'($urandom_range(0, 2)) : mem_lat;
        end
    end

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        n;
        logic        s;
        logic        r;
        logic [31:0] rpc;
        logic [1:0]  lat;
        logic        v;
        logic        pc_chk;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        req;
        logic [31:0] addr;
    } vec_t;

    function automatic vec_t mk(bit n, bit s, bit r, logic [31:0] rpc, logic [1:0] lat,
                                bit v, bit pc_chk, logic [31:0] pc, logic [31:0] inst,
                                bit req, logic [31:0] addr);
        vec_t x;
        x.n = n; x.s = s; x.r = r; x.rpc = rpc; x.lat = lat;
        x.v = v; x.pc_chk = pc_chk; x.pc = pc; x.inst = inst; x.req = req; x.addr = addr;
        return x;
    endfunction

    localparam int NV = 38;
    vec_t tbl [NV];

    initial begin
        logic        p_valid;
        logic [31:0] p_pc;
        logic [31:0] p_inst;
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        bit          st;
        bit          rd;
        int          consumed;

        // nrst stall redir rpc lat | valid pc_chk pc inst req addr
        tbl[0]  = mk(0,0,0,0,0,       0,1,32'h0,   NOP,                 0,32'h0);
        tbl[1]  = mk(0,0,0,0,0,       0,1,32'h0,   NOP,                 0,32'h0);
        tbl[2]  = mk(1,0,0,0,0,       0,1,32'h0,   NOP,                 0,32'h4);
        tbl[3]  = mk(1,0,0,0,0,       1,1,32'h0,   word_at(32'h0),      1,32'h4);
        tbl[4]  = mk(1,0,0,0,0,       0,1,32'h0,   NOP,                 0,32'h8);
        tbl[5]  = mk(1,0,0,0,0,       1,1,32'h4,   word_at(32'h4),      1,32'h8);
        for (int i = 6; i <= 11; i++)
            tbl[i] = mk(1,1,0,0,0,    1,1,32'h4,   word_at(32'h4),      0,32'hC);
        tbl[12] = mk(1,0,0,0,0,       1,1,32'h8,   word_at(32'h8),      1,32'hC);
        tbl[13] = mk(1,0,0,0,0,       0,1,32'h8,   NOP,                 0,32'h10);
        tbl[14] = mk(1,0,0,0,0,       1,1,32'hC,   word_at(32'hC),      1,32'h10);
        tbl[15] = mk(1,0,0,0,0,       0,1,32'hC,   NOP,                 0,32'h14);
        tbl[16] = mk(1,0,1,32'h100,0, 0,0,32'h0,   NOP,                 1,32'h100);
        tbl[17] = mk(1,0,0,0,0,       0,0,32'h0,   NOP,                 0,32'h104);
        tbl[18] = mk(1,0,0,0,0,       1,1,32'h100, word_at(32'h100),    1,32'h104);
        tbl[19] = mk(1,0,1,32'h103,0, 0,0,32'h0,   NOP,                 0,32'h100);
        tbl[20] = mk(1,0,0,0,0,       0,0,32'h0,   NOP,                 1,32'h100);
        tbl[21] = mk(1,0,0,0,0,       0,0,32'h0,   NOP,                 0,32'h104);
        tbl[22] = mk(1,0,0,0,0,       1,1,32'h100, word_at(32'h100),    1,32'h104);
        tbl[23] = mk(1,0,0,0,2,       0,1,32'h100, NOP,                 0,32'h108);
        tbl[24] = mk(1,0,1,32'h100,2, 0,0,32'h0,   NOP,                 0,32'h100);
        tbl[25] = mk(1,0,0,0,0,       0,0,32'h0,   NOP,                 0,32'h100);
        tbl[26] = mk(1,0,0,0,0,       0,0,32'h0,   NOP,                 1,32'h100);
        tbl[27] = mk(1,0,0,0,0,       0,0,32'h0,   NOP,                 0,32'h104);
        tbl[28] = mk(1,0,0,0,0,       1,1,32'h100, word_at(32'h100),    1,32'h104);
        tbl[29] = mk(1,1,0,0,0,       1,1,32'h100, word_at(32'h100),    0,32'h108);
        tbl[30] = mk(1,1,0,0,0,       1,1,32'h100, word_at(32'h100),    0,32'h108);
        tbl[31] = mk(0,1,0,0,0,       0,1,32'h0,   NOP,                 0,32'h0);
        tbl[32] = mk(1,0,0,0,0,       0,1,32'h0,   NOP,                 0,32'h4);
        tbl[33] = mk(1,0,0,0,0,       1,1,32'h0,   word_at(32'h0),      1,32'h4);
        tbl[34] = mk(1,0,0,0,0,       0,1,32'h0,   NOP,                 0,32'h8);
        tbl[35] = mk(0,0,0,0,0,       0,1,32'h0,   NOP,                 0,32'h0);
        tbl[36] = mk(1,0,0,0,0,       0,1,32'h0,   NOP,                 0,32'h4);
        tbl[37] = mk(1,0,0,0,0,       1,1,32'h0,   word_at(32'h0),      1,32'h4);

        for (int i = 0; i < NV; i++) begin
            nrst          = tbl[i].n;
            stall_i       = tbl[i].s;
            redirect_i    = tbl[i].r;
            redirect_pc_i = tbl[i].rpc;
            mem_lat       = int'(tbl[i].lat);
            if (i == 2) begin
                #1;
                check(imem_req == 1'b1, "req_first_cycle", 32'(imem_req), 32'h1);
                check(w_addr == 32'hFFFF_FFFC, "wrap_first_addr", w_addr, 32'hFFFF_FFFC);
            end
            tick();
            check(if_valid_o == tbl[i].v,    $sformatf("v%0d_valid", i), 32'(if_valid_o), 32'(tbl[i].v));
            check(if_inst_o  == tbl[i].inst, $sformatf("v%0d_inst", i),  if_inst_o, tbl[i].inst);
            check(imem_req   == tbl[i].req,  $sformatf("v%0d_req", i),   32'(imem_req), 32'(tbl[i].req));
            check(imem_addr  == tbl[i].addr, $sformatf("v%0d_addr", i),  imem_addr, tbl[i].addr);
            if (tbl[i].pc_chk)
                check(if_pc_o == tbl[i].pc,  $sformatf("v%0d_pc", i),    if_pc_o, tbl[i].pc);
            if (i == 2)
                check(w_addr == 32'h0, "wrap_second_addr", w_addr, 32'h0);
            if (i == 3) begin
                check(w_valid && w_pc == 32'hFFFF_FFFC, "wrap_pc", w_pc, 32'hFFFF_FFFC);
                check(w_inst == word_at(32'hFFFF_FFFC), "wrap_inst", w_inst, word_at(32'hFFFF_FFFC));
            end
        end

        // Randomized phase: in-order stream scoreboard
        mem_rand = 1'b1;
        consumed = 0;
        exp_pc   = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            st  = ($urandom_range(0, 99) < 30);
            rd  = (cyc == 0) || ($urandom_range(0, 99) < 6);
            tgt = (cyc == 0) ? 32'h0000_1000 : $urandom();
            stall_i       = st;
            redirect_i    = rd;
            redirect_pc_i = tgt;
            p_valid = if_valid_o;
            p_pc    = if_pc_o;
            p_inst  = if_inst_o;
            tick();
            if (rd) begin
                exp_pc = {tgt[31:2], 2'b00};
                check(!if_valid_o && if_inst_o == NOP, "rnd_redirect_bubble", if_inst_o, NOP);
            end else begin
                if (p_valid && !st) begin
                    check(p_pc == exp_pc, "rnd_order_pc", p_pc, exp_pc);
                    check(p_inst == word_at(p_pc), "rnd_inst_pairing", p_inst, word_at(p_pc));
                    exp_pc = exp_pc + 32'd4;
                    consumed++;
                end
                if (p_valid && st)
                    check(if_valid_o && if_pc_o == p_pc && if_inst_o == p_inst,
                          "rnd_stall_hold", if_pc_o, p_pc);
                if (!if_valid_o)
                    check(if_inst_o == NOP, "rnd_bubble_nop", if_inst_o, NOP);
            end
        end
        check(consumed >= 200, "rnd_progress", 32'(consumed), 32'd200);

        stall_i    = 1'b0;
        redirect_i = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
